// File: rtl/pe_act_unit.sv
// ---------------------------------------------------------------------------
// pe_act_unit
//   Multi-lane activation + requantisation stage at the PE accumulator output.
//   Each beat carries LANES signed IW-bit accumulator words. Every lane goes
//   through the selected activation and a rounded (half-up) arithmetic right
//   shift in S1. S2 then saturates each lane to signed OW bits. The result is
//   handed downstream over a valid/ready stream. Throughput is one beat per
//   clock, and latency is two cycles when the stream is not stalled.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_mode           0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU
//   cfg_shift          requant right shift (0..IW-1)
//   cfg_leak           leaky slope 2^-cfg_leak
//   cfg_clip           unsigned clip ceiling used in mode 3
//   in_valid/in_ready  input handshake; in_data lane i at [i*IW +: IW]
//   out_valid/out_ready output handshake; out_data lane i at [i*OW +: OW]
//   busy               a beat is held in S1 or S2
//
// Optional feature (macro PE_ACT_ZCNT_EN)
//   Adds cnt_clr, zero_cnt and sat_cnt. On every output pop, the counters add
//   the number of zero lanes and the number of clamped lanes. They saturate
//   at 2^32-1. cnt_clr is synchronous and wins over a same-cycle increment.
// ---------------------------------------------------------------------------
module pe_act_unit #(
  parameter int LANES = 4,
  parameter int IW    = 24,
  parameter int OW    = 8,
  parameter int SH_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [SH_W-1:0]       cfg_shift,
  input  logic [2:0]            cfg_leak,
  input  logic [OW-1:0]         cfg_clip,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*OW-1:0]   out_data,
`ifdef PE_ACT_ZCNT_EN
  input  logic                  cnt_clr,
  output logic [31:0]           zero_cnt,
  output logic [31:0]           sat_cnt,
`endif
  output logic                  busy
);

  // One extra bit so that adding the rounding term cannot overflow.
  localparam int RW = IW + 1;
  localparam logic signed [RW-1:0] OMAX = RW'((1 << (OW - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  localparam logic [1:0] MODE_BYP  = 2'd0;
  localparam logic [1:0] MODE_LEAK = 2'd2;
  localparam logic [1:0] MODE_CLIP = 2'd3;

  // S1 state
  logic                  s1_valid;
  logic signed [RW-1:0]  s1_r [LANES];
  logic [1:0]            s1_mode;
  logic [OW-1:0]         s1_clip;

  // S2 state (out_valid / out_data are the S2 registers)
  logic [LANES-1:0]      s2_sat;

  logic                  s1_en;
  logic                  s2_en;

  // Handshake enables
  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
    busy     = s1_valid || out_valid;
  end

  // S1 combinational: activation followed by rounded arithmetic shift
  logic signed [IW-1:0]  x_lane [LANES];
  logic signed [IW-1:0]  a_lane [LANES];
  logic signed [RW-1:0]  r_nxt  [LANES];
  logic signed [RW-1:0]  rnd;

  always_comb begin
    rnd = '0;
    if (cfg_shift != '0) begin
      rnd = $signed(RW'(1) << (cfg_shift - SH_W'(1)));
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x_lane[i] = $signed(in_data[i*IW +: IW]);
      case (cfg_mode)
        MODE_BYP:  a_lane[i] = x_lane[i];
        MODE_LEAK: a_lane[i] = x_lane[i][IW-1] ? (x_lane[i] >>> cfg_leak) : x_lane[i];
        default:   a_lane[i] = x_lane[i][IW-1] ? '0 : x_lane[i];
      endcase
      r_nxt[i] = (RW'(a_lane[i]) + rnd) >>> cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_clip  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_r[i] <= '0;
      end
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        // Config travels with the beat, so later config changes cannot touch it.
        s1_mode <= cfg_mode;
        s1_clip <= cfg_clip;
        for (int i = 0; i < LANES; i++) begin
          s1_r[i] <= r_nxt[i];
        end
      end
    end
  end

  // S2 combinational: saturation into the OW-bit output range
  logic [OW-1:0]         clip_top;
  logic signed [RW-1:0]  hi_lim;
  logic signed [RW-1:0]  lo_lim;
  logic [LANES*OW-1:0]   q_nxt;
  logic [LANES-1:0]      sat_nxt;

  always_comb begin
    // Any clip value with the MSB set is above the positive output limit.
    clip_top = s1_clip[OW-1] ? {1'b0, {(OW-1){1'b1}}} : s1_clip;
    if (s1_mode == MODE_CLIP) begin
      hi_lim = $signed({{(RW-OW){1'b0}}, clip_top});
      lo_lim = '0;
    end else begin
      hi_lim = OMAX;
      lo_lim = OMIN;
    end
    q_nxt   = '0;
    sat_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_r[i] > hi_lim) begin
        q_nxt[i*OW +: OW] = hi_lim[OW-1:0];
        sat_nxt[i]        = 1'b1;
      end else if (s1_r[i] < lo_lim) begin
        q_nxt[i*OW +: OW] = lo_lim[OW-1:0];
        sat_nxt[i]        = 1'b1;
      end else begin
        q_nxt[i*OW +: OW] = s1_r[i][OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s2_sat    <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= q_nxt;
        s2_sat   <= sat_nxt;
      end
    end
  end

`ifdef PE_ACT_ZCNT_EN
  localparam int CW = $clog2(LANES + 1);

  logic [CW-1:0] n_zero;
  logic [CW-1:0] n_sat;
  logic [32:0]   zero_sum;
  logic [32:0]   sat_sum;

  always_comb begin
    n_zero = '0;
    n_sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_data[i*OW +: OW] == '0) n_zero = n_zero + CW'(1);
      if (s2_sat[i])                  n_sat  = n_sat + CW'(1);
    end
    zero_sum = {1'b0, zero_cnt} + 33'(n_zero);
    sat_sum  = {1'b0, sat_cnt} + 33'(n_sat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
      sat_cnt  <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= '0;
      sat_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      // A carry out means the count passed 2^32-1, so the counter sticks at all-ones.
      zero_cnt <= zero_sum[32] ? '1 : zero_sum[31:0];
      sat_cnt  <= sat_sum[32]  ? '1 : sat_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pe_act_unit.sv
module tb_pe_act_unit;
  localparam int LANES = 4;
  localparam int IW    = 24;
  localparam int OW    = 8;
  localparam int SH_W  = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          cfg_mode = '0;
  logic [SH_W-1:0]     cfg_shift = '0;
  logic [2:0]          cfg_leak = '0;
  logic [OW-1:0]       cfg_clip = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*IW-1:0] in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [LANES*OW-1:0] out_data;
  logic                busy;
`ifdef PE_ACT_ZCNT_EN
  logic                cnt_clr = 1'b0;
  logic [31:0]         zero_cnt;
  logic [31:0]         sat_cnt;
`endif

  pe_act_unit #(.LANES(LANES), .IW(IW), .OW(OW), .SH_W(SH_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mode  (cfg_mode),
    .cfg_shift (cfg_shift),
    .cfg_leak  (cfg_leak),
    .cfg_clip  (cfg_clip),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PE_ACT_ZCNT_EN
    .cnt_clr   (cnt_clr),
    .zero_cnt  (zero_cnt),
    .sat_cnt   (sat_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          nsat;
    int          nzero;
    int          acc_cyc;
    bit          has_lit;
    logic [31:0] lit;
  } beat_t;

  beat_t       q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  longint      m_zero = 0;
  longint      m_sat = 0;
  bit          saw_stall = 1'b0;
  bit          dr_has_lit = 1'b0;
  logic [31:0] dr_lit = '0;

  // Monitor scratch
  int          mn;
  bit          exp_ov;
  beat_t       e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: lane value = sat(floor((act(x) + half) / 2^shift))
  function automatic void model(input logic [95:0] din, input logic [1:0] mode,
                                input logic [4:0] sh, input logic [2:0] leak,
                                input logic [7:0] clip, output logic [31:0] dout,
                                output int nsat, output int nzero);
    longint x, a, r, lo, hi, rnd;
    logic [23:0] f;
    dout = '0; nsat = 0; nzero = 0;
    for (int i = 0; i < 4; i++) begin
      f = din[i*24 +: 24];
      x = f[23] ? longint'(f) - (longint'(1) << 24) : longint'(f);
      case (mode)
        2'd0:    a = x;
        2'd2:    a = (x < 0) ? (x >>> leak) : x;
        default: a = (x < 0) ? 0 : x;
      endcase
      rnd = (sh == 0) ? 0 : (longint'(1) << (int'(sh) - 1));
      r = (a + rnd) >>> sh;
      hi = 127; lo = -128;
      if (mode == 2'd3) begin
        lo = 0;
        hi = (int'(clip) < 127) ? longint'(clip) : 127;
      end
      if (r > hi) begin r = hi; nsat++; end
      else if (r < lo) begin r = lo; nsat++; end
      if (r == 0) nzero++;
      dout[i*8 +: 8] = r[7:0];
    end
  endfunction

  function automatic logic [95:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [95:0] v;
    v[23:0] = l0[23:0]; v[47:24] = l1[23:0]; v[71:48] = l2[23:0]; v[95:72] = l3[23:0];
    return v;
  endfunction

  function automatic logic [31:0] pk8(input int l0, input int l1, input int l2, input int l3);
    logic [31:0] v;
    v[7:0] = l0[7:0]; v[15:8] = l1[7:0]; v[23:16] = l2[7:0]; v[31:24] = l3[7:0];
    return v;
  endfunction

  // Per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
`ifdef PE_ACT_ZCNT_EN
      chk("rst_zero_cnt", zero_cnt, 32'h0);
      chk("rst_sat_cnt", sat_cnt, 32'h0);
`endif
      q.delete();
      m_zero = 0;
      m_sat = 0;
    end else begin
      mn = q.size();
      chk("inflight_le2", (mn <= 2), 1'b1);
      chk("busy", busy, (mn > 0));
      chk("in_ready", in_ready, !(mn == 2 && !out_ready));
      exp_ov = (mn > 0) && (cyc - q[0].acc_cyc >= 2);
      chk("out_valid", out_valid, exp_ov);
      if (out_valid && mn > 0) begin
        chk("out_data", out_data, q[0].exp);
        if (q[0].has_lit) chk("out_data_literal", out_data, q[0].lit);
      end
`ifdef PE_ACT_ZCNT_EN
      chk("zero_cnt", zero_cnt, m_zero[31:0]);
      chk("sat_cnt", sat_cnt, m_sat[31:0]);
`endif
      if (in_valid && !in_ready) saw_stall = 1'b1;
`ifdef PE_ACT_ZCNT_EN
      if (cnt_clr) begin
        m_zero = 0;
        m_sat = 0;
      end else if (out_valid && out_ready && mn > 0) begin
        m_zero = m_zero + q[0].nzero;
        m_sat  = m_sat + q[0].nsat;
        if (m_zero > 64'hFFFF_FFFF) m_zero = 64'hFFFF_FFFF;
        if (m_sat > 64'hFFFF_FFFF) m_sat = 64'hFFFF_FFFF;
      end
`endif
      if (out_valid && out_ready && mn > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        model(in_data, cfg_mode, cfg_shift, cfg_leak, cfg_clip, e.exp, e.nsat, e.nzero);
        e.acc_cyc = cyc;
        e.has_lit = dr_has_lit;
        e.lit     = dr_lit;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [95:0] d, input logic [1:0] m, input logic [4:0] s,
                      input logic [2:0] lk, input logic [7:0] cl,
                      input bit hl, input logic [31:0] lt);
    in_data = d; cfg_mode = m; cfg_shift = s; cfg_leak = lk; cfg_clip = cl;
    dr_has_lit = hl; dr_lit = lt; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        dr_has_lit = 1'b0;
        return;
      end
      tick();
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    in_valid = 1'b0;
    dr_has_lit = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max; k++) begin
      if (q.size() == 0) return;
      tick();
    end
    n_vec++; n_err++;
    $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
  endtask

  task automatic stream8();
    for (int b = 0; b < 8; b++) begin
      send(pk(b * 3 - 7, 100 + b, -b, b * 50), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 20)),
           1'b0, '0);
    end
  endtask

  task automatic ready_pattern();
    tick(); tick(); tick();
    out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    out_ready = 1'b1;
  endtask

  function automatic int rnd_lane();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 40)) - 20;
    return int'($urandom_range(0, 32'h00FF_FFFF));
  endfunction

`ifdef PE_ACT_ZCNT_EN
  logic [31:0] sat0, zero0;
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ReLU, shift 0
    send(pk(-5, 7, 200, 0), 2'd1, 5'd0, 3'd0, 8'd0, 1'b1, pk8(0, 7, 127, 0));
    drain(10);
    // Leaky, leak 3, shift 2
    send(pk(-64, 10, -1, 3), 2'd2, 5'd2, 3'd3, 8'd0, 1'b1, pk8(-2, 3, 0, 1));
    drain(10);
    // Clip at 6
    send(pk(-3, 4, 6, 100), 2'd3, 5'd0, 3'd0, 8'd6, 1'b1, pk8(0, 4, 6, 6));
    drain(10);
    // Bypass extremes
`ifdef PE_ACT_ZCNT_EN
    sat0 = sat_cnt; zero0 = zero_cnt;
`endif
    send(pk(-1000, 'h7FFFFF, -128, 127), 2'd0, 5'd0, 3'd0, 8'd0, 1'b1, pk8(-128, 127, -128, 127));
    drain(10);
    tick();
`ifdef PE_ACT_ZCNT_EN
    chk("sat_cnt_incr", sat_cnt - sat0, 32'd2);
    chk("zero_cnt_incr", zero_cnt - zero0, 32'd0);
`endif
    // clip ceiling 0
    send(pk(50, -3, 100, 0), 2'd3, 5'd0, 3'd0, 8'd0, 1'b1, pk8(0, 0, 0, 0));
    drain(10);
    // maximum shift, half-up rounding at +/-0.5
    send(pk('h7FFFFF, -8388608, 4194304, -4194304), 2'd0, 5'd23, 3'd0, 8'd0, 1'b1, pk8(1, -1, 1, 0));
    drain(10);

    // Backpressure: 8 beats, out_ready low for 4 clocks
    fork
      stream8();
      ready_pattern();
    join
    drain(20);
    chk("stall_seen", saw_stall, 1'b1);

    // Mode change between beats, then reset with two beats in flight
    send(pk(-5, 7, 200, 0), 2'd1, 5'd0, 3'd0, 8'd0, 1'b1, pk8(0, 7, 127, 0));
    send(pk(-5, 7, 200, 0), 2'd0, 5'd0, 3'd0, 8'd0, 1'b1, pk8(-5, 7, 127, 0));
    drain(10);
    out_ready = 1'b0;
    send(pk(1, 2, 3, 4), 2'd0, 5'd0, 3'd0, 8'd0, 1'b0, '0);
    send(pk(5, 6, 7, 8), 2'd1, 5'd0, 3'd0, 8'd0, 1'b0, '0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) tick();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_shift = 5'($urandom_range(0, 23));
      cfg_leak  = 3'($urandom_range(0, 7));
      cfg_clip  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef PE_ACT_ZCNT_EN
      cnt_clr   = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef PE_ACT_ZCNT_EN
    cnt_clr = 1'b0;
`endif
    drain(20);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
